// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - issue/writeback/status bundle for hazard_scoreboard
//
// Purpose: groups the decode issue port, the writeback port, the flush
// strobe and the scoreboard status outputs into one bundle.
//   master : pipeline side, drives issue_*, wb_*, flush; reads stall, pending_cnt
//   slave  : scoreboard side
// stall_cycles exists only when SCOREBOARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
  parameter int NREGS = 32,
  parameter int LATW  = 3
);
  localparam int IDXW = $clog2(NREGS);
  localparam int PCW  = IDXW + 1;

  logic            issue_valid;
  logic [IDXW-1:0] issue_rd;
  logic            issue_we;
  logic [LATW-1:0] issue_lat;
  logic [IDXW-1:0] issue_ra;
  logic [IDXW-1:0] issue_rb;
  logic            issue_use_ra;
  logic            issue_use_rb;
  logic            wb_valid;
  logic [IDXW-1:0] wb_rd;
  logic            flush;
  logic            stall;
  logic [PCW-1:0]  pending_cnt;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]     stall_cycles;
`endif

  modport master (
    output issue_valid, issue_rd, issue_we, issue_lat,
    output issue_ra, issue_rb, issue_use_ra, issue_use_rb,
    output wb_valid, wb_rd, flush,
`ifdef SCOREBOARD_STATS_EN
    input  stall_cycles,
`endif
    input  stall, pending_cnt
  );

  modport slave (
    input  issue_valid, issue_rd, issue_we, issue_lat,
    input  issue_ra, issue_rb, issue_use_ra, issue_use_rb,
    input  wb_valid, wb_rd, flush,
`ifdef SCOREBOARD_STATS_EN
    output stall_cycles,
`endif
    output stall, pending_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - producer-side hazard scoreboard for the multicycle pipeline
//
// Purpose: tracks every in-flight destination register and the cycles left
// until its result reaches the forwarding point. Decode stalls while a source
// operand is not yet forwardable, or while a new write would overtake an
// older incomplete write to the same register. Entries clear at writeback.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : asynchronous active-high, clears all state
//   bus   : hazard_scoreboard_if.slave (issue, writeback, flush, stall,
//           pending_cnt, optional stall_cycles)
// Optional feature: SCOREBOARD_STATS_EN adds the saturating stall_cycles counter.
module hazard_scoreboard #(
  parameter int NREGS = 32,
  parameter int LATW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   bus
);
  localparam int IDXW = $clog2(NREGS);
  localparam int PCW  = IDXW + 1;

  logic [NREGS-1:0] r_pending;
  logic [LATW-1:0]  r_cnt [NREGS];
  logic [PCW-1:0]   r_pending_cnt;

  logic [NREGS-1:0] w_pending_nxt;
  logic [LATW-1:0]  w_cnt_nxt [NREGS];
  logic [PCW-1:0]   w_pcnt_nxt;
  logic             w_haz_ra;
  logic             w_haz_rb;
  logic             w_haz_waw;
  logic             w_stall;
  logic             w_accept;
  logic             w_wb;

  // A pending entry whose count reached zero is already forwardable, so it
  // blocks neither reads nor a new write to the same register.
  assign w_haz_ra  = bus.issue_use_ra && (bus.issue_ra != '0) &&
                     r_pending[bus.issue_ra] && (r_cnt[bus.issue_ra] != '0);
  assign w_haz_rb  = bus.issue_use_rb && (bus.issue_rb != '0) &&
                     r_pending[bus.issue_rb] && (r_cnt[bus.issue_rb] != '0);
  assign w_haz_waw = bus.issue_we && (bus.issue_rd != '0) &&
                     r_pending[bus.issue_rd] && (r_cnt[bus.issue_rd] != '0);
  assign w_stall   = bus.issue_valid && (w_haz_ra || w_haz_rb || w_haz_waw);
  assign w_accept  = bus.issue_valid && !w_stall && bus.issue_we &&
                     (bus.issue_rd != '0) && !bus.flush;
  assign w_wb      = bus.wb_valid && (bus.wb_rd != '0);

  // Priority, lowest to highest: countdown, writeback, accept, flush.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      w_pending_nxt[i] = r_pending[i];
      w_cnt_nxt[i]     = (r_cnt[i] != '0) ? r_cnt[i] - 1'b1 : r_cnt[i];
    end
    if (w_wb) begin
      w_pending_nxt[bus.wb_rd] = 1'b0;
      w_cnt_nxt[bus.wb_rd]     = '0;
    end
    if (w_accept) begin
      w_pending_nxt[bus.issue_rd] = 1'b1;
      w_cnt_nxt[bus.issue_rd]     = bus.issue_lat;
    end
    if (bus.flush) begin
      for (int i = 0; i < NREGS; i++) begin
        w_pending_nxt[i] = 1'b0;
        w_cnt_nxt[i]     = '0;
      end
    end
    w_pending_nxt[0] = 1'b0;
    w_cnt_nxt[0]     = '0;
  end

  // Popcount of the next pending vector so pending_cnt moves on the same edge.
  always_comb begin
    w_pcnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_pcnt_nxt = w_pcnt_nxt + PCW'(w_pending_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending     <= '0;
      r_pending_cnt <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_pending     <= w_pending_nxt;
      r_pending_cnt <= w_pcnt_nxt;
      for (int i = 0; i < NREGS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign bus.stall       = w_stall;
  assign bus.pending_cnt = r_pending_cnt;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] r_stall_cycles;

  // Flushed stall cycles are not counted; saturates rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall && !bus.flush && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  hazard_scoreboard_if #(.NREGS(32), .LATW(3)) bus ();

  hazard_scoreboard #(.NREGS(32), .LATW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       we;
    logic [4:0] rd;
    logic [2:0] lat;
    logic       ua;
    logic [4:0] ra;
    logic       ub;
    logic [4:0] rb;
    logic       wv;
    logic [4:0] wrd;
    logic       fl;
    logic       es;
    logic [5:0] ep;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] exp_q[$];
  int         exp_stats;

  function automatic vec_t mk(logic v, logic we, logic [4:0] rd, logic [2:0] lat,
                              logic ua, logic [4:0] ra, logic ub, logic [4:0] rb,
                              logic wv, logic [4:0] wrd, logic fl,
                              logic es, logic [5:0] ep);
    vec_t t;
    t.v = v; t.we = we; t.rd = rd; t.lat = lat;
    t.ua = ua; t.ra = ra; t.ub = ub; t.rb = rb;
    t.wv = wv; t.wrd = wrd; t.fl = fl; t.es = es; t.ep = ep;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.issue_valid  = t.v;
    bus.issue_we     = t.we;
    bus.issue_rd     = t.rd;
    bus.issue_lat    = t.lat;
    bus.issue_use_ra = t.ua;
    bus.issue_ra     = t.ra;
    bus.issue_use_rb = t.ub;
    bus.issue_rb     = t.rb;
    bus.wb_valid     = t.wv;
    bus.wb_rd        = t.wrd;
    bus.flush        = t.fl;
  endtask

  initial begin
    vec_t idle;
    logic [5:0] e;
    clk = 1'b0;
    reset = 1'b1;
    n_checks = 0;
    n_fail = 0;
    exp_stats = 0;
    idle = mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
    drive(idle);

    //      v we rd lat ua ra ub rb wv wrd fl  stall pcnt
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0,0)); // idle
    vecs.push_back(mk(1,0, 0,0, 1,5, 0,0, 0, 0,0, 0,0)); // read r5, nothing pending
    vecs.push_back(mk(1,1, 5,2, 0,0, 0,0, 0, 0,0, 0,1)); // issue r5 lat2
    vecs.push_back(mk(1,0, 0,0, 1,5, 0,0, 0, 0,0, 1,1)); // t+1 stall
    vecs.push_back(mk(1,0, 0,0, 1,5, 0,0, 0, 0,0, 1,1)); // t+2 stall
    vecs.push_back(mk(1,0, 0,0, 1,5, 0,0, 0, 0,0, 0,1)); // t+3 released
    vecs.push_back(mk(1,1, 5,3, 0,0, 0,0, 0, 0,0, 0,1)); // reissue r5, cnt 0 -> no WAW
    vecs.push_back(mk(1,0, 0,0, 0,0, 1,5, 0, 0,0, 1,1));
    vecs.push_back(mk(1,0, 0,0, 0,0, 1,5, 0, 0,0, 1,1));
    vecs.push_back(mk(1,0, 0,0, 0,0, 1,5, 0, 0,0, 1,1));
    vecs.push_back(mk(1,0, 0,0, 0,0, 1,5, 0, 0,0, 0,1)); // released after 3
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 5,0, 0,0)); // writeback r5
    vecs.push_back(mk(1,1, 7,1, 0,0, 0,0, 0, 0,0, 0,1)); // issue r7 lat1
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0, 0,1)); // cnt7 -> 0
    vecs.push_back(mk(1,1, 7,1, 0,0, 0,0, 1, 7,0, 0,1)); // accept + wb r7: accept wins
    vecs.push_back(mk(1,0, 0,0, 1,7, 0,0, 0, 0,0, 1,1)); // reloaded cnt7 = 1
    vecs.push_back(mk(1,0, 0,0, 1,7, 0,0, 0, 0,0, 0,1));
    vecs.push_back(mk(1,1, 9,4, 0,0, 0,0, 0, 0,0, 0,2)); // issue r9 lat4
    vecs.push_back(mk(1,1, 9,2, 0,0, 0,0, 0, 0,0, 1,2)); // WAW stall, not accepted
    vecs.push_back(mk(1,1, 3,4, 0,0, 0,0, 0, 0,0, 0,3)); // issue r3 lat4
    vecs.push_back(mk(1,1,12,2, 0,0, 0,0, 1, 9,1, 0,0)); // flush beats issue and wb
    vecs.push_back(mk(1,0, 0,0, 1,3, 1,9, 0, 0,0, 0,0)); // r3/r9 no longer stall
    vecs.push_back(mk(1,1, 0,7, 0,0, 0,0, 0, 0,0, 0,0)); // rd=0 never pending
    vecs.push_back(mk(1,0, 0,0, 1,0, 1,0, 0, 0,0, 0,0)); // read r0
    vecs.push_back(mk(1,1, 4,3, 0,0, 0,0, 0, 0,0, 0,1)); // issue r4 lat3
    vecs.push_back(mk(1,0, 0,0, 1,4, 0,0, 0, 0,1, 1,0)); // stalled read under flush
    vecs.push_back(mk(1,0, 0,0, 1,4, 0,0, 0, 0,0, 0,0)); // stall gone after flush
    vecs.push_back(mk(1,1, 6,5, 0,0, 0,0, 0, 0,0, 0,1)); // issue r6 lat5
    vecs.push_back(mk(1,0, 0,0, 1,6, 0,0, 1, 6,0, 1,0)); // stalled read + wb r6
    vecs.push_back(mk(1,0, 0,0, 1,6, 0,0, 0, 0,0, 0,0)); // stall gone after wb
    vecs.push_back(mk(0,1,10,2, 0,0, 0,0, 0, 0,0, 0,0)); // no issue_valid -> no accept
    vecs.push_back(mk(0,0, 0,0, 0,0, 0,0, 1,11,0, 0,0)); // wb to idle reg is a no-op

    #2;
    check("reset_stall", {31'd0, bus.stall}, 32'd0);
    check("reset_pending_cnt", {26'd0, bus.pending_cnt}, 32'd0);
`ifdef SCOREBOARD_STATS_EN
    check("reset_stall_cycles", bus.stall_cycles, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("stall[%0d]", i), {31'd0, bus.stall}, {31'd0, vecs[i].es});
      if (vecs[i].es && !vecs[i].fl) exp_stats++;
      exp_q.push_back(vecs[i].ep);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check($sformatf("queue_underflow[%0d]", i), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("pending_cnt[%0d]", i), {26'd0, bus.pending_cnt}, {26'd0, e});
      end
    end

`ifdef SCOREBOARD_STATS_EN
    check("stall_cycles", bus.stall_cycles, exp_stats);
`endif

    // Asynchronous reset mid-operation: state must clear with no clock edge.
    @(negedge clk);
    drive(mk(1,1, 8,6, 0,0, 0,0, 0, 0,0, 0,0));
    @(posedge clk);
    #1;
    drive(mk(1,0, 0,0, 1,8, 0,0, 0, 0,0, 0,0));
    #1;
    check("pre_reset_pending_cnt", {26'd0, bus.pending_cnt}, 32'd1);
    check("pre_reset_stall", {31'd0, bus.stall}, 32'd1);
    reset = 1'b1;
    #1;
    check("async_reset_pending_cnt", {26'd0, bus.pending_cnt}, 32'd0);
    check("async_reset_stall", {31'd0, bus.stall}, 32'd0);
`ifdef SCOREBOARD_STATS_EN
    check("async_reset_stall_cycles", bus.stall_cycles, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    drive(idle);
    @(posedge clk);
    #1;
    check("post_reset_pending_cnt", {26'd0, bus.pending_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
